// File: rtl/ppu_vram_arbiter.sv
// Shares the single PPU VRAM port between render fetch, palette colour load and the CPU data port.
// One access in flight at a time: IDLE picks a winner, ADDR drives the port, WAIT/DATA return read data.
module ppu_vram_arbiter #(
  parameter int RD_LAT       = 1,
  parameter int CPU_MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_active,
  input  logic        rnd_req,
  input  logic [15:0] rnd_addr,
  output logic        rnd_gnt,
  output logic        rnd_done,
  input  logic        col_req,
  input  logic [15:0] col_addr,
  output logic        col_gnt,
  output logic        col_done,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [7:0]  rd_data,
  output logic [15:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_data_in,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;

  localparam logic [1:0] OWN_RND  = 2'd0;
  localparam logic [1:0] OWN_COL  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);
  localparam logic [1:0] LAT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  state_t      state, state_nxt;
  logic [1:0]  owner;
  logic        owner_we;
  logic [1:0]  lat_cnt;
  logic [7:0]  wait_cnt;
  logic        cpu_first;
  logic        pick_vld;
  logic [1:0]  pick;
  logic [15:0] pick_addr;

  // Winner selection; only consumed while IDLE
  always_comb begin
    cpu_first = !frame_active || (wait_cnt >= MAX_WAIT);
    pick_vld  = rnd_req || col_req || cpu_req;
    pick      = OWN_RND;
    if (cpu_first) begin
      if (cpu_req)      pick = OWN_CPU;
      else if (rnd_req) pick = OWN_RND;
      else if (col_req) pick = OWN_COL;
    end else begin
      if (rnd_req)      pick = OWN_RND;
      else if (col_req) pick = OWN_COL;
      else if (cpu_req) pick = OWN_CPU;
    end
    case (pick)
      OWN_COL: pick_addr = col_addr;
      OWN_CPU: pick_addr = cpu_addr;
      default: pick_addr = rnd_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ADDR;
      ADDR:    state_nxt = (RD_LAT == 1) ? DATA : WAIT;
      WAIT:    if (lat_cnt == LAT_LAST) state_nxt = DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access registers: address/strobe capture on grant, read capture on entry to DATA
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_RND;
      owner_we   <= 1'b0;
      lat_cnt    <= 2'd0;
      vram_addr  <= 16'd0;
      vram_wdata <= 8'd0;
      rd_data    <= 8'd0;
    end else begin
      if (state == IDLE && pick_vld) begin
        owner     <= pick;
        owner_we  <= (pick == OWN_CPU) && cpu_we;
        vram_addr <= pick_addr;
        if (pick == OWN_CPU) vram_wdata <= cpu_wdata;
      end
      if (state == ADDR)      lat_cnt <= 2'd0;
      else if (state == WAIT) lat_cnt <= lat_cnt + 2'd1;
      if ((state == ADDR || state == WAIT) && state_nxt == DATA && !owner_we)
        rd_data <= vram_data_in;
    end
  end

  // CPU starvation counter, saturating
  always_ff @(posedge clk) begin
    if (rst || !cpu_req || cpu_gnt) wait_cnt <= 8'd0;
    else if (wait_cnt != 8'hFF)     wait_cnt <= wait_cnt + 8'd1;
  end

  always_comb begin
    rnd_gnt  = (state == ADDR) && (owner == OWN_RND);
    col_gnt  = (state == ADDR) && (owner == OWN_COL);
    cpu_gnt  = (state == ADDR) && (owner == OWN_CPU);
    rnd_done = (state == DATA) && (owner == OWN_RND);
    col_done = (state == DATA) && (owner == OWN_COL);
    cpu_done = (state == DATA) && (owner == OWN_CPU);
    vram_we  = (state == ADDR) && owner_we;
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter: one instance at RD_LAT=1, one at RD_LAT=3 sharing the inputs.
// VRAM is modelled as data = addr[7:0] ^ addr[15:8] ^ 8'h82.
module tb_ppu_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_active;
  logic        rnd_req, col_req, cpu_req, cpu_we;
  logic [15:0] rnd_addr, col_addr, cpu_addr;
  logic [7:0]  cpu_wdata;

  logic        rnd_gnt, rnd_done, col_gnt, col_done, cpu_gnt, cpu_done, vram_we, busy;
  logic [7:0]  rd_data, vram_wdata, vram_data_in;
  logic [15:0] vram_addr;

  logic        u3_rnd_gnt, u3_rnd_done, u3_col_gnt, u3_col_done, u3_cpu_gnt, u3_cpu_done;
  logic        u3_vram_we, u3_busy;
  logic [7:0]  u3_rd_data, u3_vram_wdata, u3_vram_data_in;
  logic [15:0] u3_vram_addr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign vram_data_in    = vram_addr[7:0] ^ vram_addr[15:8] ^ 8'h82;
  assign u3_vram_data_in = u3_vram_addr[7:0] ^ u3_vram_addr[15:8] ^ 8'h82;

  ppu_vram_arbiter #(.RD_LAT(1), .CPU_MAX_WAIT(16)) u1 (
    .clk(clk), .rst(rst), .frame_active(frame_active),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_gnt(rnd_gnt), .rnd_done(rnd_done),
    .col_req(col_req), .col_addr(col_addr), .col_gnt(col_gnt), .col_done(col_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .rd_data(rd_data),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_data_in(vram_data_in), .busy(busy)
  );

  ppu_vram_arbiter #(.RD_LAT(3), .CPU_MAX_WAIT(16)) u3 (
    .clk(clk), .rst(rst), .frame_active(frame_active),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_gnt(u3_rnd_gnt), .rnd_done(u3_rnd_done),
    .col_req(col_req), .col_addr(col_addr), .col_gnt(u3_col_gnt), .col_done(u3_col_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(u3_cpu_gnt), .cpu_done(u3_cpu_done), .rd_data(u3_rd_data),
    .vram_addr(u3_vram_addr), .vram_we(u3_vram_we), .vram_wdata(u3_vram_wdata),
    .vram_data_in(u3_vram_data_in), .busy(u3_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits for the next grant (bounded), drops the granted requester's req
  task automatic next_grant(output logic [2:0] g, output int n);
    g = 3'b000;
    n = 0;
    while (g == 3'b000 && n < 20) begin
      tick();
      n++;
      g = {cpu_gnt, col_gnt, rnd_gnt};
    end
    if (g[0]) rnd_req = 1'b0;
    if (g[1]) col_req = 1'b0;
    if (g[2]) cpu_req = 1'b0;
  endtask

  initial begin
    logic [2:0] g;
    int n, rg, cpu_cyc, dcnt, dcyc, colseen, rstdone;
    logic [7:0] wc, dd;
    logic got;

    rst = 1'b1; frame_active = 1'b0;
    rnd_req = 1'b0; col_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    rnd_addr = 16'h0; col_addr = 16'h0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    tick(); tick();

    check("rst_ctrl", {rnd_gnt, rnd_done, col_gnt, col_done, cpu_gnt, cpu_done, vram_we, busy}, 8'h00);
    check("rst_addr", vram_addr, 16'h0000);
    check("rst_wdata", vram_wdata, 8'h00);
    check("rst_rdata", rd_data, 8'h00);

    // T1: reset during a CPU write in ADDR
    rst = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3F10; cpu_wdata = 8'h55;
    tick();
    check("t1_gnt", cpu_gnt, 1'b1);
    check("t1_we_addr", vram_we, 1'b1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    rst = 1'b1;
    tick();
    check("t1_we_off", vram_we, 1'b0);
    check("t1_busy", {busy, u3_busy}, 2'b00);
    check("t1_addr", vram_addr, 16'h0000);
    check("t1_wdata", vram_wdata, 8'h00);
    rstdone = int'(cpu_done);
    tick(); rstdone += int'(cpu_done);
    tick(); rstdone += int'(cpu_done);
    check("t1_no_done", rstdone, 0);
    check("t1_waitcnt", u1.wait_cnt, 8'h00);
    rst = 1'b0;
    tick();

    // T2: single render read, RD_LAT=1
    rnd_req = 1'b1; rnd_addr = 16'h2005;
    tick();
    check("t2_gnt", rnd_gnt, 1'b1);
    check("t2_addr", vram_addr, 16'h2005);
    check("t2_busy1", busy, 1'b1);
    rnd_req = 1'b0;
    tick();
    check("t2_done", {rnd_done, rnd_gnt}, 2'b10);
    check("t2_rdata", rd_data, 8'hA7);
    tick();
    check("t2_idle", {busy, rnd_done}, 2'b00);

    // T3a: rendering priority RND > COL > CPU
    frame_active = 1'b1;
    rnd_req = 1'b1; rnd_addr = 16'h2005;
    col_req = 1'b1; col_addr = 16'h3F01;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    next_grant(g, n); check("t3a_g1", g, 3'b001); check("t3a_n1", n, 1);
    next_grant(g, n); check("t3a_g2", g, 3'b010); check("t3a_n2", n, 3);
    next_grant(g, n); check("t3a_g3", g, 3'b100); check("t3a_n3", n, 3);
    tick(); tick();

    // T3b: vblank priority CPU > RND > COL
    frame_active = 1'b0;
    rnd_req = 1'b1; col_req = 1'b1; cpu_req = 1'b1;
    next_grant(g, n); check("t3b_g1", g, 3'b100); check("t3b_n1", n, 1);
    next_grant(g, n); check("t3b_g2", g, 3'b001); check("t3b_n2", n, 3);
    next_grant(g, n); check("t3b_g3", g, 3'b010); check("t3b_n3", n, 3);
    tick(); tick();

    // T4: CPU starvation override under continuous render traffic
    frame_active = 1'b1;
    rnd_req = 1'b1; rnd_addr = 16'h2005;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    cyc = 0; rg = 0; cpu_cyc = -1; wc = 8'h00; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (rnd_gnt) rg++;
      if (cpu_gnt) begin
        got = 1'b1;
        cpu_cyc = cyc;
        wc = u1.wait_cnt;
        cpu_req = 1'b0;
        rnd_req = 1'b0;
      end
    end
    check("t4_cpu_cycle", cpu_cyc, 19);
    check("t4_rnd_grants", rg, 6);
    check("t4_waitcnt_at_gnt", wc, 8'd19);
    tick();
    check("t4_waitcnt_clr", u1.wait_cnt, 8'h00);
    check("t4_done", cpu_done, 1'b1);
    check("t4_rdata", rd_data, 8'hA4);
    tick();

    // T5: CPU write
    frame_active = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3F00; cpu_wdata = 8'h0F;
    tick();
    check("t5_gnt", cpu_gnt, 1'b1);
    check("t5_we", vram_we, 1'b1);
    check("t5_addr", vram_addr, 16'h3F00);
    check("t5_wdata", vram_wdata, 8'h0F);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("t5_we_off", vram_we, 1'b0);
    check("t5_done", cpu_done, 1'b1);
    check("t5_rdata_held", rd_data, 8'hA4);
    tick();
    check("t5_idle", {busy, cpu_done}, 2'b00);

    // T6: abandoned colour request during a render read; RD_LAT=3 latency
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    cyc = 0;
    rnd_req = 1'b1; rnd_addr = 16'h00C3;
    tick();
    check("t6_gnt3", u3_rnd_gnt, 1'b1);
    check("t6_addr3", u3_vram_addr, 16'h00C3);
    rnd_req = 1'b0;
    col_req = 1'b1; col_addr = 16'h3F01;
    tick();
    col_req = 1'b0;
    colseen = 0; dcnt = 0; dcyc = -1; dd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      colseen += int'(col_gnt) + int'(col_done) + int'(u3_col_gnt) + int'(u3_col_done);
      if (u3_rnd_done) begin
        dcnt++;
        dcyc = cyc;
        dd = u3_rd_data;
      end
      tick();
    end
    check("t6_no_col", colseen, 0);
    check("t6_done_cnt", dcnt, 1);
    check("t6_done_cycle", dcyc, 4);
    check("t6_rdata3", dd, 8'h41);
    check("t6_idle3", u3_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected $finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
